multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// combinational datapath enables, and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                hold,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                MemtoReg,
    output logic                ALUSrc,
    output logic                Branch,
    output logic [1:0]          ALUop,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_R    = 3'd1,
        OP_I    = 3'd2,
        OP_LW   = 3'd3,
        OP_SW   = 3'd4,
        OP_BR   = 3'd5
    } op_class_t;

    state_t    state_q;
    op_class_t op_q;
    op_class_t dec_class;
    logic      dec_nop;
    logic      dec_legal;

    assign state = state_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_class = OP_NONE;
        dec_nop   = 1'b0;
        dec_legal = 1'b1;
        case (opcode)
            7'b0110011: dec_class = OP_R;
            7'b0010011: dec_class = OP_I;
            7'b0000011: dec_class = OP_LW;
            7'b0100011: dec_class = OP_SW;
            7'b1100011: dec_class = OP_BR;
            7'b0000000: dec_nop   = 1'b1;
            default:    dec_legal = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= OP_NONE;
            retired <= '0;
        end else if (!hold) begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= dec_class;
                    if (dec_class != OP_NONE) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_FETCH;
                        if (dec_nop) retired <= retired + RETIRE_W'(1);
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW: state_q <= S_MEM;
                        OP_R, OP_I:   state_q <= S_WB;
                        OP_BR: begin
                            state_q <= S_FETCH;
                            retired <= retired + RETIRE_W'(1);
                        end
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op_q == OP_LW) begin
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FETCH;
                            retired <= retired + RETIRE_W'(1);
                        end
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    retired <= retired + RETIRE_W'(1);
                end
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Reset blanks every output, even though FETCH would otherwise drive MemRead.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        ALUop    = 2'b00;
        illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_DECODE: illegal = !dec_legal;
                S_EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW: ALUSrc = 1'b1;
                        OP_I: begin
                            ALUSrc = 1'b1;
                            ALUop  = 2'b10;
                        end
                        OP_R:  ALUop = 2'b10;
                        OP_BR: begin
                            ALUop   = 2'b01;
                            Branch  = 1'b1;
                            PCWrite = branch_taken;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (op_q == OP_LW);
                    MemWrite = (op_q == OP_SW);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (op_q == OP_LW);
                end
                default: ;
            endcase
            // A held cycle must not commit anything, including a ready memory access.
            if (hold) begin
                PCWrite  = 1'b0;
                IRWrite  = 1'b0;
                MemRead  = 1'b0;
                MemWrite = 1'b0;
                RegWrite = 1'b0;
                illegal  = 1'b0;
            end
        end
    end

endmodule
